// File: rtl/cp0_exc_commit_pkg.sv
// Shared CP0 constants: register addresses ({rd, sel}), field bit positions and ExcCode values.
package cp0_exc_commit_pkg;

  localparam logic [7:0] Cp0AddrBadVAddr = {5'd8, 3'd0};
  localparam logic [7:0] Cp0AddrCount    = {5'd9, 3'd0};
  localparam logic [7:0] Cp0AddrCompare  = {5'd11, 3'd0};
  localparam logic [7:0] Cp0AddrStatus   = {5'd12, 3'd0};
  localparam logic [7:0] Cp0AddrCause    = {5'd13, 3'd0};
  localparam logic [7:0] Cp0AddrEpc      = {5'd14, 3'd0};

  localparam int unsigned StatusIeBit  = 0;
  localparam int unsigned StatusExlBit = 1;
  localparam int unsigned StatusImLsb  = 8;
  localparam int unsigned StatusImMsb  = 15;

  localparam int unsigned CauseExcLsb = 2;
  localparam int unsigned CauseExcMsb = 6;
  localparam int unsigned CauseIpLsb  = 8;
  localparam int unsigned CauseIpMsb  = 15;
  localparam int unsigned CauseTiBit  = 30;
  localparam int unsigned CauseBdBit  = 31;

  typedef enum logic [4:0] {
    ExcInt  = 5'h00,
    ExcAdEL = 5'h04,
    ExcAdES = 5'h05,
    ExcSys  = 5'h08,
    ExcBp   = 5'h09,
    ExcRI   = 5'h0a,
    ExcOv   = 5'h0c
  } exc_code_e;

  // Only address-error exceptions capture the faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == ExcAdEL) || (code == ExcAdES);
  endfunction

endpackage

// File: rtl/cp0_exc_commit_timer.sv
// Count/Compare timer with TI flag; present only when CP0_TIMER_INT_EN is defined.
`ifdef CP0_TIMER_INT_EN
module cp0_exc_commit_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        tick_q;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end
    // A Compare write acknowledges the timer and beats a simultaneous match.
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if ((count_we_i || tick_q) && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= ~tick_q;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule
`endif

// File: rtl/cp0_exc_commit.sv
// Commits exception/ERET/MTC0 records into CP0 and issues a registered flush pulse.
// Define CP0_TIMER_INT_EN to include the Count/Compare timer and its interrupt.
module cp0_exc_commit
  import cp0_exc_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        commit_valid,
  input  logic [31:0] pc,
  input  logic [31:0] badvaddr,
  input  logic [4:0]  excCode,
  input  logic        is_exc,
  input  logic        is_in_ds,
  input  logic        is_eret,
  input  logic        mtc0_we,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [5:0]  ext_int,
  output logic        int_pending,
  output logic        flush,
  output logic [31:0] flush_pc
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  logic        take_exc, take_eret, take_mtc0;
  logic [31:0] count, compare;
  logic        ti;
  logic [7:0]  cause_ip;
  logic [31:0] cause_rd;

  assign take_exc  = commit_valid & is_exc;
  assign take_eret = commit_valid & ~is_exc & is_eret;
  assign take_mtc0 = commit_valid & ~is_exc & ~is_eret & mtc0_we;

`ifdef CP0_TIMER_INT_EN
  logic wr_count, wr_compare;
  assign wr_count   = take_mtc0 && (cp0_addr == Cp0AddrCount);
  assign wr_compare = take_mtc0 && (cp0_addr == Cp0AddrCompare);

  cp0_exc_commit_timer u_timer (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .count_we_i   (wr_count),
    .compare_we_i (wr_compare),
    .wdata_i      (wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  assign cause_ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  always_comb begin
    cause_rd = '0;
    cause_rd[CauseBdBit]              = bd_q;
    cause_rd[CauseTiBit]              = ti;
    cause_rd[CauseIpMsb:CauseIpLsb]   = cause_ip;
    cause_rd[CauseExcMsb:CauseExcLsb] = exc_code_q;
  end

  always_comb begin
    case (cp0_addr)
      Cp0AddrBadVAddr: rdata = badvaddr_q;
      Cp0AddrCount:    rdata = count;
      Cp0AddrCompare:  rdata = compare;
      Cp0AddrStatus:   rdata = status_q;
      Cp0AddrCause:    rdata = cause_rd;
      Cp0AddrEpc:      rdata = epc_q;
      default:         rdata = '0;
    endcase
  end

  assign int_pending = status_q[StatusIeBit] & ~status_q[StatusExlBit] &
                       |(cause_ip & status_q[StatusImMsb:StatusImLsb]);

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    flush_d    = take_exc | take_eret;
    flush_pc_d = flush_pc_q;
    if (take_exc) begin
      status_d[StatusExlBit] = 1'b1;
      exc_code_d             = excCode;
      // Nested exceptions keep the original return point.
      if (!status_q[StatusExlBit]) begin
        epc_d = pc;
        bd_d  = is_in_ds;
      end
      if (is_addr_exc(excCode)) begin
        badvaddr_d = badvaddr;
      end
      flush_pc_d = EXC_VECTOR;
    end else if (take_eret) begin
      status_d[StatusExlBit] = 1'b0;
      flush_pc_d             = epc_q;
    end else if (take_mtc0) begin
      case (cp0_addr)
        Cp0AddrStatus: begin
          status_d[StatusImMsb:StatusImLsb] = wdata[StatusImMsb:StatusImLsb];
          status_d[StatusExlBit]            = wdata[StatusExlBit];
          status_d[StatusIeBit]             = wdata[StatusIeBit];
        end
        Cp0AddrCause: ip_sw_d = wdata[CauseIpLsb+1:CauseIpLsb];
        Cp0AddrEpc:   epc_d   = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ext_int;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

endmodule
